// File: rtl/retry_sched.sv
// Per-core request retry scheduler: round-robin injection, timeout/drop retry
// with exponential backoff, and a saturating collision counter.
`ifndef N
`define N 8
`endif

module retry_sched #(
  parameter int unsigned N            = `N,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned BACKOFF_BASE = 2,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_valid,
  output logic [N-1:0] req_ack,
  output logic [N-1:0] inject_valid,
  output logic [1:0]   inject_pri,
  input  logic [N-1:0] dropped_vec,
  input  logic [N-1:0] resp_valid,
  output logic [N-1:0] done,
  output logic [N-1:0] fail,
  output logic [N-1:0] busy,
  input  logic         collision_any,
  output logic [15:0]  collision_cnt
);

  localparam int unsigned PW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW     = $clog2(MAX_RETRY + 1) + 2;
  localparam int unsigned TW     = ($clog2(TIMEOUT) + 1 > 5) ? $clog2(TIMEOUT) + 1 : 5;
  localparam int unsigned BO_MAX = BACKOFF_BASE << MAX_RETRY;
  localparam int unsigned BW     = $clog2(BO_MAX + 1);

  typedef enum logic [1:0] {IDLE, PEND, WAIT, BACKOFF} state_t;

  state_t        state     [N];
  logic [RW-1:0] retry_cnt [N];
  logic [TW-1:0] timer     [N];
  logic [BW-1:0] bo_cnt    [N];
  logic [PW-1:0] rr_ptr;

  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   scan;
  logic [RW-1:0] pri_src;

  // Round-robin pick of the first PEND core at or after rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(N)) scan = scan - (PW+1)'(N);
      if (!gnt_any && state[scan[PW-1:0]] == PEND) begin
        gnt_any = 1'b1;
        gnt_idx = scan[PW-1:0];
      end
    end
  end

  // Injection is combinational from the grant; priority is the capped retry count.
  always_comb begin
    inject_valid = '0;
    inject_pri   = 2'd0;
    pri_src      = '0;
    if (gnt_any) begin
      inject_valid[gnt_idx] = 1'b1;
      pri_src               = retry_cnt[gnt_idx];
      inject_pri            = (pri_src > RW'(3)) ? 2'd3 : pri_src[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state[i]     <= IDLE;
        retry_cnt[i] <= '0;
        timer[i]     <= '0;
        bo_cnt[i]    <= '0;
      end
      rr_ptr        <= '0;
      collision_cnt <= '0;
      req_ack       <= '0;
      done          <= '0;
      fail          <= '0;
      busy          <= '0;
    end else begin
      req_ack <= '0;
      done    <= '0;
      fail    <= '0;
      for (int i = 0; i < N; i++) begin
        case (state[i])
          IDLE: begin
            if (req_valid[i]) begin
              req_ack[i]   <= 1'b1;
              retry_cnt[i] <= '0;
              state[i]     <= PEND;
              busy[i]      <= 1'b1;
            end
          end
          PEND: begin
            if (gnt_any && gnt_idx == PW'(i)) begin
              state[i] <= WAIT;
              timer[i] <= '0;
            end
          end
          WAIT: begin
            // A response beats a drop or timeout in the same cycle.
            if (resp_valid[i]) begin
              done[i]  <= 1'b1;
              state[i] <= IDLE;
              busy[i]  <= 1'b0;
            end else if (dropped_vec[i] || timer[i] == TW'(TIMEOUT - 1)) begin
              if (retry_cnt[i] < RW'(MAX_RETRY)) begin
                retry_cnt[i] <= retry_cnt[i] + 1'b1;
                bo_cnt[i]    <= BW'(BACKOFF_BASE) << (retry_cnt[i] + 1'b1);
                state[i]     <= BACKOFF;
              end else begin
                fail[i]  <= 1'b1;
                state[i] <= IDLE;
                busy[i]  <= 1'b0;
              end
            end else begin
              timer[i] <= timer[i] + 1'b1;
            end
          end
          BACKOFF: begin
            if (bo_cnt[i] == BW'(1)) state[i] <= PEND;
            else                     bo_cnt[i] <= bo_cnt[i] - 1'b1;
          end
          default: state[i] <= IDLE;
        endcase
      end
      if (gnt_any) rr_ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      if (collision_any && collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
    end
  end

endmodule
